hazard_unit: RTL

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for a five-stage in-order core.
//
// It resolves four kinds of hazard:
//   - operand forwarding into Execute from Memory or Writeback
//   - load-use stalls, which insert one bubble into Execute
//   - control flushes when a branch or jump resolves as taken in Execute
//   - data-memory wait stalls, bounded by a timeout that raises mem_err
//
// Optional feature: define HAZARD_PERF_COUNT_EN to build the saturating
// stall and flush performance counters. When it is undefined, both counter
// ports are tied to zero and no counter flops are built.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | pipeline flowing; the wait counter is held at zero
// MEM_WAIT | data memory is busy; the whole pipe is held and the wait
//          | counter advances toward MEM_TIMEOUT
module hazard_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        ResultSrcE0,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        mem_req_M,
    input  logic        mem_ready,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        mem_err,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0]  FWD_RF = 2'b00;
    localparam logic [1:0]  FWD_W  = 2'b01;
    localparam logic [1:0]  FWD_M  = 2'b10;

    // Wait-counter value on the last wait cycle before the timeout fires.
    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;

    logic timeout_cycle;
    logic timeout_err;
    logic memwait;
    logic lwstall;

    // Detect the memory timeout, the memory-wait condition and load-use hazards.
    always_comb begin
        timeout_cycle = (state == MEM_WAIT) && (wait_cnt == WAIT_LAST);
        memwait       = mem_req_M && !mem_ready && !timeout_cycle;
        // If mem_ready arrives in the timeout cycle, the access completes
        // normally and is not reported as an error.
        timeout_err   = timeout_cycle && mem_req_M && !mem_ready;
        lwstall       = ResultSrcE0 && (RdE != 5'd0) &&
                        ((RdE == Rs1D) || (RdE == Rs2D));
    end

    // Select the ALU operand sources. The Memory stage holds the younger
    // result, so it has priority over Writeback.
    always_comb begin
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (reset) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
                ForwardAE = FWD_M;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
                ForwardAE = FWD_W;

            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
                ForwardBE = FWD_M;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
                ForwardBE = FWD_W;
        end
    end

    // Drive the stall and flush outputs. Reset flushes the whole pipe.
    // A memory wait freezes every stage and bubbles Writeback. A taken
    // branch overrides a load-use stall. During a wait, a taken branch is
    // held off; it flushes D and E in the cycle the wait releases.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallE  = 1'b0;
        StallM  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        FlushW  = 1'b0;
        mem_err = 1'b0;
        if (!reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else if (memwait) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            // The timed-out access never produced data, so Writeback gets a
            // bubble and no stage is stalled in the release cycle.
            if (timeout_err) begin
                FlushW  = 1'b1;
                mem_err = 1'b1;
            end
            if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lwstall && !timeout_err) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Compute the next state. Leave MEM_WAIT as soon as the wait condition
    // drops; that happens on ready, on timeout, or when the request goes away.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (memwait)  state_nxt = MEM_WAIT;
            MEM_WAIT: if (!memwait) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // Update the state register and the wait counter. The counter is cleared
    // in RUN and advances once per MEM_WAIT cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == MEM_WAIT)
                wait_cnt <= wait_cnt + 16'd1;
            else
                wait_cnt <= 16'd0;
        end
    end

`ifdef HAZARD_PERF_COUNT_EN
    // Count stalled cycles and flush cycles, saturating at all-ones. The
    // counters are held at zero during reset, so the reset flushes are not
    // counted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (StallF && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if ((FlushD || FlushE) && (flush_events != 32'hFFFF_FFFF))
                flush_events <= flush_events + 32'd1;
        end
    end
`else
    // Without performance counting, both counter ports are constant zero.
    always_comb begin
        stall_cycles = 32'd0;
        flush_events = 32'd0;
    end
`endif

endmodule
